// File: rtl/l2_cache_wb.sv
// l2_cache_wb: set-associative write-back, write-allocate L2 cache with true-LRU
// replacement, burst writeback of dirty victims and burst line refill.
module l2_cache_wb #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_WAYS       = 4,
    parameter int NUM_SETS       = 512,
    parameter int WORDS_PER_LINE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              readEn,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              ready,
    output logic              hit,
    output logic              miss,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    localparam int BW   = $clog2(WORDS_PER_LINE);
    localparam int WOFF = BW + 2;
    localparam int IDXW = $clog2(NUM_SETS);
    localparam int TAGW = ADDR_W - IDXW - WOFF;
    localparam int WAYW = $clog2(NUM_WAYS);
    localparam logic [BW-1:0] BEAT0     = '0;
    localparam logic [BW-1:0] BEAT_LAST = '1;

    // state  | meaning
    // IDLE   | wait for an L1 request and latch it
    // LOOKUP | tag compare; a hit completes, a miss picks the victim way
    // WB     | stream the dirty victim line out to memory
    // WB_GAP | single idle memory cycle between writeback and refill
    // REFILL | stream the requested line into the victim way
    // RESP   | raise the completion pulse
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_WB_GAP, S_REFILL, S_RESP} state_t;

    state_t                state_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q, cap_q;
    logic                  is_wr_q, lk_hit_q;
    logic [WAYW-1:0]       victim_q;
    logic [BW-1:0]         beat_q;
    logic                  ready_q, hit_q, miss_q, mem_req_q, mem_we_q;
    logic [DATA_W-1:0]     rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0]     mem_addr_q;

    logic [DATA_W-1:0]     data_q  [NUM_WAYS][NUM_SETS*WORDS_PER_LINE];
    logic [TAGW-1:0]       tag_q   [NUM_WAYS][NUM_SETS];
    logic [NUM_SETS-1:0]   valid_q [NUM_WAYS];
    logic [NUM_SETS-1:0]   dirty_q [NUM_WAYS];
    logic [WAYW-1:0]       age_q   [NUM_SETS][NUM_WAYS];

    logic [TAGW-1:0]       req_tag;
    logic [IDXW-1:0]       req_idx;
    logic [BW-1:0]         req_woff, beat_nx;
    logic                  hit_any, inv_any;
    logic [WAYW-1:0]       hit_way, inv_way, lru_way, victim, acc_way, old_age;
    logic [WAYW-1:0]       age_d   [NUM_WAYS];

    assign req_tag  = addr_q[ADDR_W-1 -: TAGW];
    assign req_idx  = addr_q[WOFF +: IDXW];
    assign req_woff = addr_q[2 +: BW];
    assign beat_nx  = beat_q + 1'b1;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        lru_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
                hit_any = 1'b1;
                hit_way = WAYW'(w);
            end
            if (age_q[req_idx][w] == WAYW'(NUM_WAYS-1))
                lru_way = WAYW'(w);
        end
        // Scan downwards so the lowest-numbered invalid way wins
        for (int w = NUM_WAYS-1; w >= 0; w--) begin
            if (!valid_q[w][req_idx]) begin
                inv_any = 1'b1;
                inv_way = WAYW'(w);
            end
        end
        victim  = inv_any ? inv_way : lru_way;
        acc_way = (state_q == S_LOOKUP) ? hit_way : victim_q;
        old_age = age_q[req_idx][acc_way];
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (WAYW'(w) == acc_way)
                age_d[w] = '0;
            else if (age_q[req_idx][w] < old_age)
                age_d[w] = age_q[req_idx][w] + 1'b1;
            else
                age_d[w] = age_q[req_idx][w];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == S_LOOKUP && hit_any && is_wr_q)
            data_q[hit_way][{req_idx, req_woff}] <= wdata_q;
        if (!rst && state_q == S_REFILL && mem_ready) begin
            data_q[victim_q][{req_idx, beat_q}] <= mem_rdata;
            if (beat_q == BEAT_LAST) begin
                tag_q[victim_q][req_idx] <= req_tag;
                if (is_wr_q)
                    data_q[victim_q][{req_idx, req_woff}] <= wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            is_wr_q     <= 1'b0;
            lk_hit_q    <= 1'b0;
            victim_q    <= '0;
            beat_q      <= '0;
            ready_q     <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            for (int w = 0; w < NUM_WAYS; w++) begin
                valid_q[w] <= '0;
                dirty_q[w] <= '0;
            end
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++)
                    age_q[s][w] <= WAYW'(w);
        end else begin
            ready_q <= 1'b0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            rdata_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (readEn || writeEn) begin
                        addr_q  <= addr;
                        wdata_q <= write_data;
                        is_wr_q <= writeEn;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    beat_q   <= '0;
                    lk_hit_q <= hit_any;
                    if (hit_any) begin
                        cap_q <= data_q[hit_way][{req_idx, req_woff}];
                        if (is_wr_q)
                            dirty_q[hit_way][req_idx] <= 1'b1;
                        for (int w = 0; w < NUM_WAYS; w++)
                            age_q[req_idx][w] <= age_d[w];
                        state_q <= S_RESP;
                    end else begin
                        victim_q  <= victim;
                        mem_req_q <= 1'b1;
                        // Victim stays readable for writeback; only its valid bit drops
                        valid_q[victim][req_idx] <= 1'b0;
                        if (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[victim][req_idx], req_idx, BEAT0, 2'b00};
                            mem_wdata_q <= data_q[victim][{req_idx, BEAT0}];
                            state_q     <= S_WB;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {req_tag, req_idx, BEAT0, 2'b00};
                            state_q    <= S_REFILL;
                        end
                    end
                end
                S_WB: begin
                    if (mem_ready) begin
                        if (beat_q == BEAT_LAST) begin
                            beat_q    <= '0;
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            state_q   <= S_WB_GAP;
                        end else begin
                            beat_q      <= beat_nx;
                            mem_addr_q  <= {tag_q[victim_q][req_idx], req_idx, beat_nx, 2'b00};
                            mem_wdata_q <= data_q[victim_q][{req_idx, beat_nx}];
                        end
                    end
                end
                S_WB_GAP: begin
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= {req_tag, req_idx, BEAT0, 2'b00};
                    state_q    <= S_REFILL;
                end
                S_REFILL: begin
                    if (mem_ready) begin
                        if (!is_wr_q && beat_q == req_woff)
                            cap_q <= mem_rdata;
                        if (beat_q == BEAT_LAST) begin
                            beat_q    <= '0;
                            mem_req_q <= 1'b0;
                            valid_q[victim_q][req_idx] <= 1'b1;
                            dirty_q[victim_q][req_idx] <= is_wr_q;
                            for (int w = 0; w < NUM_WAYS; w++)
                                age_q[req_idx][w] <= age_d[w];
                            state_q <= S_RESP;
                        end else begin
                            beat_q     <= beat_nx;
                            mem_addr_q <= {req_tag, req_idx, beat_nx, 2'b00};
                        end
                    end
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    hit_q   <= lk_hit_q;
                    miss_q  <= !lk_hit_q;
                    rdata_q <= is_wr_q ? '0 : cap_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign read_data = rdata_q;
    assign ready     = ready_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_l2_cache_wb.sv
// Testbench for l2_cache_wb: directed scenarios plus random traffic, checked
// against a line/recency-list model of the cache and a fixed-latency memory.
module tb_l2_cache_wb;
    localparam int NW = 4, NS = 512, WPL = 16;

    logic        clk = 1'b0;
    logic        rst, readEn, writeEn, ready, hit, miss, mem_req, mem_we, mem_ready;
    logic [31:0] addr, write_data, read_data, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    l2_cache_wb dut (
        .clk(clk), .rst(rst), .readEn(readEn), .writeEn(writeEn), .addr(addr),
        .write_data(write_data), .read_data(read_data), .ready(ready), .hit(hit),
        .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int n_checks = 0, n_errors = 0;

    logic [31:0] log_addr[$], log_data[$];
    bit          log_we[$];
    int          log_gap[$];
    int          idle_cnt, mcnt;

    // Memory: ack each beat two cycles after it appears, return the beat address
    initial begin
        mem_ready = 1'b0; mem_rdata = '0; mcnt = 0; idle_cnt = 0;
        forever begin
            @(negedge clk);
            if (!mem_req) idle_cnt++;
            if (rst || !mem_req) begin
                mem_ready = 1'b0; mcnt = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0; mcnt = 1;
            end else begin
                mcnt++;
                if (mcnt >= 2) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_addr;
                    log_addr.push_back(mem_addr);
                    log_data.push_back(mem_wdata);
                    log_we.push_back(mem_we);
                    log_gap.push_back(idle_cnt);
                    idle_cnt = 0;
                end
            end
        end
    end

    logic [31:0] m_tag   [NS][NW];
    bit          m_valid [NS][NW];
    bit          m_dirty [NS][NW];
    logic [31:0] m_data  [NS][NW][WPL];
    int          m_order [NS][NW];

    bit          e_hit, e_rf;
    logic [31:0] e_rd, e_rf_base;
    int          e_nwb;
    logic [31:0] e_wb_addr[WPL], e_wb_data[WPL];
    logic [31:0] obs_rd;
    logic        obs_hit, obs_miss;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s][w] = w;
            end
    endfunction

    // Recency list per set: index 0 is most recent, last index is the LRU way
    function automatic void touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < NW; i++) if (m_order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
        m_order[s][0] = w;
    endfunction

    function automatic void model_access(input bit we, input logic [31:0] a, input logic [31:0] wd);
        int s, wi, v;
        logic [31:0] tg;
        s  = int'((a / 64) % NS);
        wi = int'((a / 4) % WPL);
        tg = a / 32768;
        e_hit = 1'b0; e_rd = '0; e_nwb = 0; e_rf = 1'b0;
        e_rf_base = a & 32'hFFFF_FFC0;
        v = -1;
        for (int w = 0; w < NW; w++)
            if (m_valid[s][w] && m_tag[s][w] == tg) v = w;
        if (v >= 0) begin
            e_hit = 1'b1;
            if (we) begin m_data[s][v][wi] = wd; m_dirty[s][v] = 1'b1; end
            else e_rd = m_data[s][v][wi];
        end else begin
            for (int w = NW-1; w >= 0; w--) if (!m_valid[s][w]) v = w;
            if (v < 0) v = m_order[s][NW-1];
            if (m_valid[s][v] && m_dirty[s][v]) begin
                e_nwb = WPL;
                for (int k = 0; k < WPL; k++) begin
                    e_wb_addr[k] = m_tag[s][v] * 32768 + s * 64 + k * 4;
                    e_wb_data[k] = m_data[s][v][k];
                end
            end
            e_rf = 1'b1;
            for (int k = 0; k < WPL; k++) m_data[s][v][k] = e_rf_base + k * 4;
            m_tag[s][v] = tg; m_valid[s][v] = 1'b1; m_dirty[s][v] = we;
            if (we) m_data[s][v][wi] = wd;
            else e_rd = m_data[s][v][wi];
        end
        touch(s, v);
        if (we) e_rd = '0;
    endfunction

    task automatic do_req(input bit re, input bit we, input logic [31:0] a, input logic [31:0] wd);
        int cyc, nwb, nrf, first_rf;
        bit got;
        model_access(we, a, wd);
        log_addr.delete(); log_data.delete(); log_we.delete(); log_gap.delete();
        @(negedge clk);
        readEn = re; writeEn = we; addr = a; write_data = wd;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            got = ready;
        end
        obs_rd = read_data; obs_hit = hit; obs_miss = miss;
        readEn = 1'b0; writeEn = 1'b0;
        check($sformatf("ready_seen@%0h", a), 32'(got), 32'd1);
        if (e_hit) check($sformatf("hit_latency@%0h", a), cyc, 3);
        check($sformatf("hit@%0h", a), 32'(obs_hit), 32'(e_hit));
        check($sformatf("miss@%0h", a), 32'(obs_miss), 32'(!e_hit));
        check($sformatf("read_data@%0h", a), obs_rd, e_rd);
        nwb = 0; nrf = 0; first_rf = -1;
        foreach (log_addr[i]) begin
            if (log_we[i]) begin
                if (nwb < WPL && nrf == 0) begin
                    check($sformatf("wb_addr%0d", nwb), log_addr[i], e_wb_addr[nwb]);
                    check($sformatf("wb_data%0d", nwb), log_data[i], e_wb_data[nwb]);
                end
                nwb++;
            end else begin
                if (first_rf < 0) first_rf = i;
                check($sformatf("rf_addr%0d", nrf), log_addr[i], e_rf_base + nrf * 4);
                nrf++;
            end
        end
        check($sformatf("wb_beats@%0h", a), nwb, e_nwb);
        check($sformatf("rf_beats@%0h", a), nrf, e_rf ? WPL : 0);
        if (e_nwb > 0 && first_rf >= 0)
            check("wb_gap_cycles", log_gap[first_rf], 1);
        @(posedge clk); #1;
        check("ready_pulse_end", 32'(ready), 32'd0);
        check("rdata_idle_zero", read_data, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  32'(ready),   32'd0);
        check({tag, "_hit"},    32'(hit),     32'd0);
        check({tag, "_miss"},   32'(miss),    32'd0);
        check({tag, "_mreq"},   32'(mem_req), 32'd0);
        check({tag, "_mwe"},    32'(mem_we),  32'd0);
        check({tag, "_maddr"},  mem_addr,     32'd0);
        check({tag, "_mwdata"}, mem_wdata,    32'd0);
        check({tag, "_rdata"},  read_data,    32'd0);
    endtask

    task automatic find_wb(input string tag, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] seen;
        seen = 32'hFFFF_FFFF;
        foreach (log_addr[i]) if (log_we[i] && log_addr[i] == a) seen = log_data[i];
        check(tag, seen, d);
    endtask

    initial begin
        int unsigned tg, st, wdx, op;
        logic [31:0] a;
        int i;
        rst = 1'b1; readEn = 1'b0; writeEn = 1'b0; addr = '0; write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        do_req(1, 0, 32'h0000_1004, '0);
        check("t1_rdata", obs_rd, 32'h0000_1004);
        do_req(1, 0, 32'h0000_1008, '0);
        check("t1_hit_rdata", obs_rd, 32'h0000_1008);
        do_req(0, 1, 32'h0000_1008, 32'hDEAD_BEEF);
        do_req(1, 0, 32'h0000_1008, '0);
        check("t2_rdata", obs_rd, 32'hDEAD_BEEF);
        do_req(1, 0, 32'h0000_9000, '0);
        do_req(1, 0, 32'h0001_1000, '0);
        do_req(1, 0, 32'h0001_9000, '0);
        do_req(1, 0, 32'h0002_1000, '0);
        find_wb("t3_wb_1008", 32'h0000_1008, 32'hDEAD_BEEF);

        do_req(0, 1, 32'h0000_2010, 32'h1234_5678);
        do_req(1, 0, 32'h0000_2010, '0);
        check("t5_rdata", obs_rd, 32'h1234_5678);
        do_req(1, 0, 32'h0000_A000, '0);
        do_req(1, 0, 32'h0001_2000, '0);
        do_req(1, 0, 32'h0001_A000, '0);
        do_req(1, 0, 32'h0002_2000, '0);
        find_wb("t5_wb_2010", 32'h0000_2010, 32'h1234_5678);

        do_reset();
        do_req(1, 0, 32'h0000_1000, '0);
        do_req(1, 0, 32'h0000_9000, '0);
        do_req(1, 0, 32'h0001_1000, '0);
        do_req(1, 0, 32'h0001_9000, '0);
        do_req(1, 0, 32'h0000_1000, '0);
        do_req(1, 0, 32'h0002_1000, '0);
        check("t4_wb_count", log_we.size() > 0 ? 32'(log_we[0]) : 32'd0, 32'd0);

        do_reset();
        @(negedge clk);
        readEn = 1'b1; addr = 32'h0000_1004;
        i = 0;
        while (!(mem_req && mem_addr == 32'h0000_1014) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("t6_beat5_reached", 32'(i < 200), 32'd1);
        readEn = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("t6_midburst");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        do_req(1, 0, 32'h0000_1004, '0);
        do_req(1, 1, 32'h0000_1010, 32'hCAFE_F00D);
        do_req(1, 0, 32'h0000_1010, '0);
        check("t6_both_is_write", obs_rd, 32'hCAFE_F00D);

        for (int t = 0; t < 150; t++) begin
            tg  = $urandom_range(0, 5);
            st  = ($urandom_range(0, 1) != 0) ? 3 : 7;
            wdx = $urandom_range(0, 15);
            op  = $urandom_range(0, 2);
            a   = tg * 32768 + st * 64 + wdx * 4 + $urandom_range(0, 3);
            do_req(op != 1, op != 0, a, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
